// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART bootloader: receives a framed image into program RAM and releases the CPU.
module prog_loader #(
  parameter int CLK_DIV   = 16,
  parameter int ADDR_W    = 12,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic [ADDR_W-1:0] addr_bus,
  output logic [7:0]        data_bus,
  output logic              cpu_rst,
  output logic              loading,
  output logic              load_error,
  output logic [15:0]       byte_count
);

  localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0]     HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]     FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [16:0]       DEPTH_L = 17'(MEM_DEPTH);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_nx;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid, rx_ferr;
  logic          tick_half, tick_full;

  assign tick_half = (rx_cnt == HALF_M1);
  assign tick_full = (rx_cnt == FULL_M1);

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_state_nx = RX_START;
      // Line back high at mid start bit means a glitch, not a start.
      RX_START: if (tick_half) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && rx_bit == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (tick_full) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (rx_state == RX_IDLE || rx_state_nx != rx_state || tick_full)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_DATA && tick_full) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == RX_STOP && tick_full) begin
        rx_valid <= rx_s2;
        rx_ferr  <= !rx_s2;
      end
    end
  end

  // ---------------- Loader FSM ----------------
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHECK, S_RUN, S_ERROR
  } ld_state_t;

  ld_state_t   state, state_nx;
  logic [7:0]  len_h, len_h_nx, sum, sum_nx;
  logic [15:0] len, len_nx, count_nx, count_inc;
  logic [16:0] len_cand;
  logic        loading_nx, err_nx, cpu_rst_q, cpu_rst_nx;
  logic        mem_we, reload, go_err, is_sync;

  assign len_cand  = {1'b0, len_h, rx_shift};
  assign count_inc = byte_count + 16'd1;
  assign is_sync   = (rx_shift == 8'hA5);
  // A sync byte in RUN holds the CPU in reset from the very cycle it arrives.
  assign cpu_rst   = cpu_rst_q | reload;

  always_comb begin
    state_nx   = state;
    len_h_nx   = len_h;
    len_nx     = len;
    sum_nx     = sum;
    count_nx   = byte_count;
    loading_nx = loading;
    err_nx     = load_error;
    cpu_rst_nx = cpu_rst_q;
    mem_we     = 1'b0;
    reload     = 1'b0;
    go_err     = 1'b0;
    if (rx_valid) begin
      case (state)
        S_IDLE, S_ERROR, S_RUN: begin
          if (is_sync) begin
            state_nx   = S_LEN_H;
            loading_nx = 1'b1;
            cpu_rst_nx = 1'b1;
            count_nx   = '0;
            sum_nx     = '0;
            reload     = (state == S_RUN);
          end
        end
        S_LEN_H: begin
          len_h_nx = rx_shift;
          state_nx = S_LEN_L;
        end
        S_LEN_L: begin
          if (len_cand == '0 || len_cand > DEPTH_L) begin
            go_err = 1'b1;
          end else begin
            len_nx   = len_cand[15:0];
            state_nx = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          mem_we   = 1'b1;
          sum_nx   = sum + rx_shift;
          count_nx = count_inc;
          if (count_inc == len) state_nx = S_CHECK;
        end
        S_CHECK: begin
          if (rx_shift == sum) begin
            state_nx   = S_RUN;
            cpu_rst_nx = 1'b0;
            loading_nx = 1'b0;
            err_nx     = 1'b0;
          end else begin
            go_err = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (rx_ferr && (state == S_LEN_H || state == S_LEN_L ||
                             state == S_PAYLOAD || state == S_CHECK)) begin
      go_err = 1'b1;
    end
    if (go_err) begin
      state_nx   = S_ERROR;
      err_nx     = 1'b1;
      loading_nx = 1'b0;
      cpu_rst_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_h      <= '0;
      len        <= '0;
      sum        <= '0;
      byte_count <= '0;
      loading    <= 1'b0;
      load_error <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state      <= state_nx;
      len_h      <= len_h_nx;
      len        <= len_nx;
      sum        <= sum_nx;
      byte_count <= count_nx;
      loading    <= loading_nx;
      load_error <= err_nx;
      cpu_rst_q  <= cpu_rst_nx;
    end
  end

  // ---------------- Program RAM ----------------
  logic [7:0] mem [MEM_DEPTH];

  // Contents survive reset so a partial image is still readable afterwards.
  always_ff @(posedge clk) begin
    if (mem_we) mem[byte_count[MW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst)
      data_bus <= 8'h00;
    else if ({1'b0, addr_bus} < DEPTH_A)
      data_bus <= mem[addr_bus[MW-1:0]];
    else
      data_bus <= 8'h00;
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader.
module tb_prog_loader;
  localparam int CLK_DIV   = 16;
  localparam int ADDR_W    = 12;
  localparam int MEM_DEPTH = 4096;

  localparam int P_IDLE = 0, P_LENH = 1, P_LENL = 2, P_PAY = 3, P_CHK = 4, P_RUN = 5, P_ERR = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              uart_rx = 1'b1;
  logic [ADDR_W-1:0] addr_bus = '0;
  logic [7:0]        data_bus;
  logic              cpu_rst, loading, load_error;
  logic [15:0]       byte_count;

  prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .addr_bus(addr_bus),
    .data_bus(data_bus), .cpu_rst(cpu_rst), .loading(loading),
    .load_error(load_error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: frame rules applied byte by byte.
  int         m_ph = P_IDLE;
  logic       m_cpu = 1'b1, m_load = 1'b0, m_err = 1'b0;
  int         m_cnt = 0, m_sum = 0, m_len = 0, m_lenh = 0;
  logic [7:0] m_mem [MEM_DEPTH];
  bit         m_wr  [MEM_DEPTH];
  logic [18:0] m_last;

  logic [18:0] st_q[$];
  logic [7:0]  rd_q[$];

  task automatic m_push();
    logic [18:0] cur;
    cur = {m_cpu, m_load, m_err, 16'(m_cnt)};
    if (cur !== m_last) begin
      st_q.push_back(cur);
      m_last = cur;
    end
  endtask

  task automatic m_fail();
    m_ph = P_ERR; m_err = 1'b1; m_load = 1'b0; m_cpu = 1'b1;
    m_push();
  endtask

  task automatic m_start();
    m_ph = P_LENH; m_load = 1'b1; m_cpu = 1'b1; m_cnt = 0; m_sum = 0;
    m_push();
  endtask

  task automatic m_reset();
    m_ph = P_IDLE; m_cpu = 1'b1; m_load = 1'b0; m_err = 1'b0; m_cnt = 0; m_sum = 0;
    m_push();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      if (m_ph inside {P_LENH, P_LENL, P_PAY, P_CHK}) m_fail();
      return;
    end
    case (m_ph)
      P_IDLE, P_ERR: if (b == 8'hA5) m_start();
      P_RUN: if (b == 8'hA5) begin m_cpu = 1'b1; m_push(); m_start(); end
      P_LENH: begin m_lenh = b; m_ph = P_LENL; end
      P_LENL: begin
        m_len = m_lenh * 256 + b;
        if (m_len == 0 || m_len > MEM_DEPTH) m_fail();
        else m_ph = P_PAY;
      end
      P_PAY: begin
        m_mem[m_cnt] = b; m_wr[m_cnt] = 1'b1;
        m_sum = (m_sum + b) % 256;
        m_cnt++;
        if (m_cnt == m_len) m_ph = P_CHK;
        m_push();
      end
      P_CHK: begin
        if (b == m_sum) begin
          m_ph = P_RUN; m_cpu = 1'b0; m_load = 1'b0; m_err = 1'b0;
          m_push();
        end else m_fail();
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i], 1'b1);
  endtask

  logic rd_tag = 1'b0;
  logic rd_fire_q = 1'b0;

  task automatic read_check(input int a);
    @(negedge clk);
    addr_bus = ADDR_W'(a);
    rd_q.push_back(m_mem[a]);
    rd_tag = 1'b1;
    @(negedge clk);
    rd_tag = 1'b0;
  endtask

  // Monitor: any change in the status outputs is matched against the next expected status.
  logic        mon_en = 1'b0;
  logic [18:0] prev_st, cur_st;

  always @(posedge clk) rd_fire_q <= rd_tag;

  always @(negedge clk) begin
    cur_st = {cpu_rst, loading, load_error, byte_count};
    if (mon_en) begin
      if (cur_st !== prev_st) begin
        if (st_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL status unexpected change actual=0x%0h", cur_st);
        end else check("status", 32'(cur_st), 32'(st_q.pop_front()));
      end
      if (rd_fire_q) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL data_bus no expected value actual=0x%0h", data_bus);
        end else check("data_bus", 32'(data_bus), 32'(rd_q.pop_front()));
      end
    end
    prev_st = cur_st;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [7:0] fr[$];
  logic [7:0] b, s;
  int n, junk, bad_at;

  initial begin
    m_last = {1'b1, 1'b0, 1'b0, 16'd0};
    repeat (3) @(negedge clk);
    check("reset cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset loading", 32'(loading), 32'd0);
    check("reset load_error", 32'(load_error), 32'd0);
    check("reset byte_count", 32'(byte_count), 32'd0);
    check("reset data_bus", 32'(data_bus), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // Glitch and idle junk must not disturb anything.
    uart_rx = 1'b0;
    repeat (CLK_DIV / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h77, 1'b0);

    // Good image.
    fr = '{8'hA5, 8'h00, 8'h03, 8'h81, 8'h05, 8'h00, 8'h86};
    send_frame(fr);
    check("run cpu_rst", 32'(cpu_rst), 32'd0);
    check("run byte_count", 32'(byte_count), 32'd3);
    for (int a = 0; a < 3; a++) read_check(a);

    // Bad checksum, then the good frame again.
    fr = '{8'hA5, 8'h00, 8'h03, 8'h81, 8'h05, 8'h00, 8'h87};
    send_frame(fr);
    check("bad chk load_error", 32'(load_error), 32'd1);
    fr = '{8'hA5, 8'h00, 8'h03, 8'h81, 8'h05, 8'h00, 8'h86};
    send_frame(fr);
    check("recover load_error", 32'(load_error), 32'd0);

    // Length bounds.
    fr = '{8'hA5, 8'h00, 8'h00};
    send_frame(fr);
    check("len0 byte_count", 32'(byte_count), 32'd0);
    fr = '{8'hA5, 8'h10, 8'h01};
    send_frame(fr);
    check("len4097 load_error", 32'(load_error), 32'd1);

    // Reload from RUN with a 2-byte image.
    fr = '{8'hA5, 8'h00, 8'h03, 8'h81, 8'h05, 8'h00, 8'h86};
    send_frame(fr);
    fr = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h30};
    send_frame(fr);
    read_check(0);
    read_check(1);

    // Framing error on payload byte 2.
    fr = '{8'hA5, 8'h00, 8'h04, 8'h11};
    send_frame(fr);
    send_byte(8'h22, 1'b0);
    check("ferr byte_count", 32'(byte_count), 32'd1);

    // Reset in the middle of a payload.
    fr = '{8'hA5, 8'h00, 8'h05, 8'hAA, 8'hBB};
    send_frame(fr);
    m_reset();
    rst = 1'b1;
    @(negedge clk);
    check("midrst cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst loading", 32'(loading), 32'd0);
    check("midrst byte_count", 32'(byte_count), 32'd0);
    check("midrst data_bus", 32'(data_bus), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    read_check(0);

    // Randomized frames with junk, bad checksums and framing errors.
    for (int it = 0; it < 12; it++) begin
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 1'b1);
      end
      n = $urandom_range(1, 6);
      bad_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      s = 8'h00;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(n[7:0], 1'b1);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        s = s + b;
        send_byte(b, j != bad_at);
      end
      send_byte(($urandom_range(0, 3) == 0) ? s + 8'd1 : s, 1'b1);
      for (int a = 0; a < n; a++) if (m_wr[a]) read_check(a);
    end

    repeat (4 * CLK_DIV) @(negedge clk);
    check("status queue drained", 32'(st_q.size()), 32'd0);
    check("read queue drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
